// File: rtl/fb_scanout.sv
// Framebuffer scan-out: upscales a small RGB565 framebuffer onto the active video area,
// with solid, checkerboard and gradient test modes and timing delayed to match the read latency.
module fb_scanout #(
   parameter int unsigned FB_WIDTH     = 320,
   parameter int unsigned FB_HEIGHT    = 180,
   parameter int unsigned SCALE_SHIFT  = 2,
   parameter int unsigned BRAM_LATENCY = 2,
   parameter int unsigned H_ACTIVE     = 1280,
   parameter int unsigned V_ACTIVE     = 720,
   parameter int unsigned CHECK_SHIFT  = 5
) (
   input  logic                                      clk_in,
   input  logic                                      rst_in,
   input  logic [10:0]                               hcount_in,
   input  logic [9:0]                                vcount_in,
   input  logic                                      ad_in,
   input  logic                                      hs_in,
   input  logic                                      vs_in,
   input  logic                                      nf_in,
   input  logic [1:0]                                mode_in,
   input  logic [15:0]                               solid_color_in,
   output logic [$clog2(FB_WIDTH*FB_HEIGHT)-1:0]     fb_addr_out,
   input  logic [15:0]                               fb_data_in,
   output logic [7:0]                                red_out,
   output logic [7:0]                                green_out,
   output logic [7:0]                                blue_out,
   output logic                                      ad_out,
   output logic                                      hs_out,
   output logic                                      vs_out,
   output logic [1:0]                                mode_out
);

   localparam int unsigned AW = $clog2(FB_WIDTH*FB_HEIGHT);
   localparam int unsigned BL = BRAM_LATENCY;

   function automatic logic [23:0] expand565(input logic [15:0] c);
      return {c[15:11], c[15:13], c[10:5], c[10:9], c[4:0], c[4:2]};
   endfunction

   logic [10:0]   col_c;
   logic [9:0]    row_c;
   logic          in_range_c;
   logic          vis_c;
   logic [1:0]    eff_mode_c;
   logic [23:0]   pat_c;
   logic [AW-1:0] row_base;
   logic [1:0]    mode_q;

   logic [BL:0]   vis_p;
   logic [BL:0]   ad_p;
   logic [BL:0]   hs_p;
   logic [BL:0]   vs_p;
   logic [1:0]    mode_p [0:BL];
   logic [23:0]   pat_p  [0:BL];

   // Sample decode: scaled coordinates, visibility, effective mode and pattern colour.
   always_comb begin
      col_c      = hcount_in >> SCALE_SHIFT;
      row_c      = vcount_in >> SCALE_SHIFT;
      in_range_c = (hcount_in < 11'(H_ACTIVE)) && (vcount_in < 10'(V_ACTIVE)) &&
                   (col_c < 11'(FB_WIDTH)) && (row_c < 10'(FB_HEIGHT));
      vis_c      = ad_in && in_range_c;
      eff_mode_c = nf_in ? mode_in : mode_q;
      pat_c      = '0;
      case (eff_mode_c)
         2'd1:    pat_c = expand565(solid_color_in);
         2'd2:    pat_c = (hcount_in[CHECK_SHIFT] ^ vcount_in[CHECK_SHIFT]) ? 24'hFF_FFFF : 24'h00_0000;
         2'd3:    pat_c = {hcount_in[7:0], vcount_in[7:0], 8'h00};
         default: pat_c = '0;
      endcase
   end

   // Address generation; row_base steps one framebuffer row after the last replicated line.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         fb_addr_out <= '0;
         row_base    <= '0;
         mode_q      <= 2'd0;
      end else begin
         fb_addr_out <= in_range_c ? row_base + AW'(col_c) : '0;
         mode_q      <= eff_mode_c;
         if (vcount_in >= 10'(V_ACTIVE)) begin
            row_base <= '0;
         end else if ((hcount_in == 11'(H_ACTIVE)) && (&vcount_in[SCALE_SHIFT-1:0])) begin
            row_base <= row_base + AW'(FB_WIDTH);
         end
      end
   end

   // Side-band delay line covering the address register plus the framebuffer read.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         vis_p <= '0;
         ad_p  <= '0;
         hs_p  <= '0;
         vs_p  <= '0;
         for (int i = 0; i <= int'(BL); i++) begin
            mode_p[i] <= 2'd0;
            pat_p[i]  <= 24'd0;
         end
      end else begin
         vis_p     <= {vis_p[BL-1:0], vis_c};
         ad_p      <= {ad_p[BL-1:0], ad_in};
         hs_p      <= {hs_p[BL-1:0], hs_in};
         vs_p      <= {vs_p[BL-1:0], vs_in};
         mode_p[0] <= eff_mode_c;
         pat_p[0]  <= pat_c;
         for (int i = 1; i <= int'(BL); i++) begin
            mode_p[i] <= mode_p[i-1];
            pat_p[i]  <= pat_p[i-1];
         end
      end
   end

   // Output stage: merges framebuffer data with the delayed pattern and timing.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         {red_out, green_out, blue_out} <= 24'd0;
         ad_out <= 1'b0;
         hs_out <= 1'b0;
         vs_out <= 1'b0;
      end else begin
         ad_out <= ad_p[BL];
         hs_out <= hs_p[BL];
         vs_out <= vs_p[BL];
         if (!vis_p[BL]) begin
            {red_out, green_out, blue_out} <= 24'd0;
         end else if (mode_p[BL] == 2'd0) begin
            {red_out, green_out, blue_out} <= expand565(fb_data_in);
         end else begin
            {red_out, green_out, blue_out} <= pat_p[BL];
         end
      end
   end

   assign mode_out = mode_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Randomized raster bench for fb_scanout: a behavioural pixel model plus a framebuffer
// memory model predict address, colour, timing and mode for every cycle.
module tb_fb_scanout;

   localparam int FBW = 320, FBH = 180, S = 2, BL = 2, HA = 1280, VA = 720, CS = 5;
   localparam int L = BL + 2, HT = 1650, VT = 750, N = 20000;
   localparam int AW = $clog2(FBW*FBH);

   logic          clk = 1'b0;
   logic          rst_in = 1'b0;
   logic [10:0]   hcount_in = '0;
   logic [9:0]    vcount_in = '0;
   logic          ad_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0, nf_in = 1'b0;
   logic [1:0]    mode_in = '0;
   logic [15:0]   solid_color_in = '0;
   logic [AW-1:0] fb_addr_out;
   logic [15:0]   fb_data_in = '0;
   logic [7:0]    red_out, green_out, blue_out;
   logic          ad_out, hs_out, vs_out;
   logic [1:0]    mode_out;

   fb_scanout #(.FB_WIDTH(FBW), .FB_HEIGHT(FBH), .SCALE_SHIFT(S), .BRAM_LATENCY(BL),
                .H_ACTIVE(HA), .V_ACTIVE(VA), .CHECK_SHIFT(CS)) dut (
      .clk_in(clk), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
      .ad_in(ad_in), .hs_in(hs_in), .vs_in(vs_in), .nf_in(nf_in), .mode_in(mode_in),
      .solid_color_in(solid_color_in), .fb_addr_out(fb_addr_out), .fb_data_in(fb_data_in),
      .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
      .ad_out(ad_out), .hs_out(hs_out), .vs_out(vs_out), .mode_out(mode_out));

   always #5 clk = ~clk;

   logic [15:0] mem [FBW*FBH];
   int e_addr [N];
   int e_rgb  [N];
   int e_tim  [N];
   int e_mode [N];
   int cyc = 0;
   int m_mode = 0;
   int checks = 0;
   int failures = 0;
   int aq [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic int exp565(input int c);
      int r, g, b;
      r = (c >> 11) & 31;
      g = (c >> 5) & 63;
      b = c & 31;
      return ((r*8 + r/4) << 16) | ((g*4 + g/16) << 8) | (b*8 + b/4);
   endfunction

   // One cycle: drive a sample, predict its results, then check what the DUT shows after the edge.
   task automatic step(input int h, input int v, input bit ad, input bit hs, input bit vs,
                       input bit nf, input int md, input int sc, input bit rst);
      int s, eff, col, row, addr, rgb, n;
      bit inr;
      s = cyc;
      hcount_in = 11'(h); vcount_in = 10'(v);
      ad_in = ad; hs_in = hs; vs_in = vs; nf_in = nf;
      mode_in = 2'(md); solid_color_in = 16'(sc); rst_in = rst;

      eff  = nf ? md : m_mode;
      col  = h / (1 << S);
      row  = v / (1 << S);
      inr  = (h < HA) && (v < VA) && (col < FBW) && (row < FBH);
      addr = inr ? row*FBW + col : 0;
      rgb  = 0;
      if (ad && inr) begin
         case (eff)
            0: rgb = exp565(int'(mem[addr]));
            1: rgb = exp565(sc);
            2: rgb = (((h / (1 << CS)) % 2) != ((v / (1 << CS)) % 2)) ? 'hFFFFFF : 0;
            default: rgb = ((h % 256) << 16) | ((v % 256) << 8);
         endcase
      end
      e_addr[s] = addr;
      e_rgb[s]  = rgb;
      e_tim[s]  = (int'(ad) << 2) | (int'(hs) << 1) | int'(vs);
      e_mode[s] = eff;
      m_mode    = eff;
      if (!rst) begin
         for (int j = s + 1 - L; j <= s; j++) begin
            if (j >= 0) begin
               e_rgb[j] = 0;
               e_tim[j] = 0;
            end
         end
         e_addr[s] = 0;
         e_mode[s] = 0;
         m_mode    = 0;
      end

      @(posedge clk);
      #1;
      cyc++;
      n = cyc;
      check("addr", 32'(fb_addr_out), 32'(e_addr[n-1]));
      check("mode", 32'(mode_out), 32'(e_mode[n-1]));
      if (n >= L) begin
         check("rgb", {8'h00, red_out, green_out, blue_out}, 32'(e_rgb[n-L]));
         check("timing", {29'd0, ad_out, hs_out, vs_out}, 32'(e_tim[n-L]));
      end

      // Framebuffer model: data for an address appears BL cycles after the address.
      aq.push_back(int'(fb_addr_out));
      if (aq.size() > BL) fb_data_in = mem[aq.pop_front()];
   endtask

   task automatic run_frame(input int start_mode, input bit wild, input int rst_line);
      int v;
      v = 0;
      while (v < VT) begin
         int nvis;
         bit jumped;
         nvis = $urandom_range(2, 5);
         jumped = 1'b0;
         for (int k = 0; k <= nvis; k++) begin
            int h, md;
            bit ad, nf, rst;
            if (k == nvis)              h = HA;
            else if (v == 9 && k == 0)  h = 5;
            else if (v == 9 && k == 1)  h = 8;
            else if ($urandom_range(0, 3) == 0) h = $urandom_range(0, HT - 1);
            else                        h = $urandom_range(0, HA - 1);
            ad  = (h < HA) && (v < VA) && ($urandom_range(0, 9) != 0);
            nf  = (v == 0 && k == 0) || (wild && $urandom_range(0, 199) == 0);
            md  = (v == 0 && k == 0) ? start_mode : int'($urandom_range(0, 3));
            rst = !(v == rst_line && k == 1);
            step(h, v, ad, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nf, md,
                 int'($urandom_range(0, 65535)), rst);
            if (!rst) begin
               jumped = 1'b1;
               break;
            end
         end
         v = jumped ? VA : v + 1;
      end
   endtask

   initial begin
      for (int i = 0; i < FBW*FBH; i++) mem[i] = 16'($urandom);
      mem[641] = 16'hF800;
      mem[642] = 16'h8410;

      repeat (L + 2) step(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Mode request without a new-frame pulse must be ignored.
      repeat (100) step(HA + 10, VA, 0, 0, 0, 0, 1, 'h07E0, 1);
      check("mode_hold", 32'(mode_out), 32'd0);
      step(HA + 10, VA, 0, 0, 0, 1, 1, 'h07E0, 1);
      check("mode_latch", 32'(mode_out), 32'd1);

      // Out-of-range sample with hsync asserted during blanking.
      step(1300, 100, 0, 1, 0, 0, 1, 'h07E0, 1);
      repeat (L) step(1400, 100, 0, 0, 0, 0, 0, 0, 1);

      run_frame(0, 1'b0, -1);
      run_frame(1, 1'b1, -1);
      run_frame(2, 1'b1, 300);
      run_frame(3, 1'b1, -1);
      repeat (L + 1) step(HA + 10, VA, 0, 0, 0, 0, 0, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
